// File: rtl/matrix_op_defs_pkg.sv
// rtl/matrix_op_defs_pkg.sv - shared sizes and writer state encoding for the matrix store
package matrix_op_defs_pkg;

  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_ADDR_WIDTH     = 10;
  localparam int MATRIX_BLOCK_SIZE     = 64;
  localparam int MATRIX_METADATA_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE,
    META0,
    META1,
    META2,
    STREAM,
    DONE
  } matrix_writer_state_e;

  function automatic logic [15:0] matrix_elem_count(input logic [7:0] rows, input logic [7:0] cols);
    return 16'(rows) * 16'(cols);
  endfunction

endpackage

// File: rtl/matrix_block_writer_if.sv
// rtl/matrix_block_writer_if.sv - producer request/stream handshake and memory write port bundle
interface matrix_block_writer_if
  import matrix_op_defs_pkg::*;
#(
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH
);
  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [0:7][7:0]       matrix_name;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  writer_ready;
  logic                  write_done;
  logic                  write_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output write_request, matrix_id, actual_rows, actual_cols, matrix_name, data_in, data_valid,
    input  write_ready, writer_ready, write_done, write_err, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  write_request, matrix_id, actual_rows, actual_cols, matrix_name, data_in, data_valid,
    output write_ready, writer_ready, write_done, write_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/matrix_block_writer.sv
// rtl/matrix_block_writer.sv - writes a matrix (3 metadata words + row-major elements) into its memory slot
module matrix_block_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [0:7][7:0]       matrix_name,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  matrix_writer_state_e  state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic [0:7][7:0]       name_q, name_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           idx_q, idx_d;
  logic                  err_q, err_d;

  logic [15:0] req_count;
  logic        req_bad;

  assign req_count = matrix_elem_count(actual_rows, actual_cols);
  assign req_bad   = (actual_rows == 8'd0) || (actual_cols == 8'd0) ||
                     (req_count > 16'(BLOCK_SIZE - MATRIX_METADATA_WORDS));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    name_d  = name_q;
    count_d = count_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (write_request) begin
          base_d  = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
          rows_d  = actual_rows;
          cols_d  = actual_cols;
          name_d  = matrix_name;
          count_d = req_count;
          idx_d   = '0;
          // A rejected request skips straight to the completion pulse with no writes.
          err_d   = req_bad;
          state_d = req_bad ? DONE : META0;
        end
      end
      META0:  state_d = META1;
      META1:  state_d = META2;
      META2:  state_d = STREAM;
      STREAM: begin
        if (data_valid) begin
          idx_d = idx_q + 16'd1;
          if (idx_q == count_q - 16'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      name_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      name_q  <= name_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign write_ready  = (state_q == IDLE);
  assign writer_ready = (state_q == STREAM);
  assign write_done   = (state_q == DONE);
  assign write_err    = err_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = base_q;
    mem_wdata = '0;
    unique case (state_q)
      META0: begin
        mem_we    = 1'b1;
        mem_wdata = DATA_WIDTH'({rows_q, cols_q, 16'h0000});
      end
      META1: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(1);
        mem_wdata = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
      end
      META2: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(2);
        mem_wdata = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
      end
      STREAM: begin
        mem_we    = data_valid;
        mem_addr  = base_q + ADDR_WIDTH'(MATRIX_METADATA_WORDS) + ADDR_WIDTH'(idx_q);
        mem_wdata = data_in;
      end
      default: ;
    endcase
    // A reset arriving mid-stream must not let the current beat reach memory.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_block_writer.sv
// tb/tb_matrix_block_writer.sv - self-checking bench for matrix_block_writer
module tb_matrix_block_writer;
  import matrix_op_defs_pkg::*;

  localparam int DW   = MATRIX_DATA_WIDTH;
  localparam int AW   = MATRIX_ADDR_WIDTH;
  localparam int BS   = MATRIX_BLOCK_SIZE;
  localparam int MAXN = BS - MATRIX_METADATA_WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_block_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matrix_block_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_request(bus.write_request),
    .write_ready  (bus.write_ready),
    .matrix_id    (bus.matrix_id),
    .actual_rows  (bus.actual_rows),
    .actual_cols  (bus.actual_cols),
    .matrix_name  (bus.matrix_name),
    .data_in      (bus.data_in),
    .data_valid   (bus.data_valid),
    .writer_ready (bus.writer_ready),
    .write_done   (bus.write_done),
    .write_err    (bus.write_err),
    .mem_we       (bus.mem_we),
    .mem_addr     (bus.mem_addr),
    .mem_wdata    (bus.mem_wdata)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    string      nm;
    logic [2:0] id;
    logic [7:0] r;
    logic [7:0] c;
    int         mode;
    int         mult;
    bit         err;
    int         lat;
  } vec_t;

  wr_t           wr_log[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int cyc = 0, done_count = 0, we_count = 0;
  int passed = 0, total = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_log.push_back('{bus.mem_addr, bus.mem_wdata});
      we_count <= we_count + 1;
    end
    if (bus.write_done) done_count <= done_count + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Producer data_valid pattern, indexed by STREAM cycle number.
  function automatic bit dv_pat(input int mode, input int k);
    case (mode)
      1:       return (k % 2) == 0;
      2:       return k >= 3;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_accept(input int r, input int c);
    return (r != 0) && (c != 0) && (r * c <= MAXN);
  endfunction

  // Request-to-write_done distance: 3 metadata cycles, then one STREAM cycle per pattern slot until n beats.
  function automatic int model_latency(input int mode, input int n);
    int got = 0;
    int l = 0;
    if (n == 0) return 1;
    while (got < n) begin
      if (dv_pat(mode, l)) got++;
      l++;
    end
    return 4 + l;
  endfunction

  task automatic run_req(input string nm, input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                         input logic [0:7][7:0] name, input int mode, input int mult,
                         input int exp_lat, input bit exp_err);
    logic [DW-1:0] dq[$];
    wr_t           exp_q[$];
    int            n, sent, k, t0, done_at, bad, w0, d0;
    bit            hs, dv, err_seen;
    logic [AW-1:0] base;
    n = exp_err ? 0 : int'(r) * int'(c);
    sent = 0; k = 0; done_at = -1; bad = 0; err_seen = 1'b0;
    for (int i = 0; i < n; i++) dq.push_back(mult != 0 ? DW'(mult * (i + 1)) : DW'($urandom));
    for (int i = 0; i < 50 && !bus.write_ready; i++) step();
    check({nm, " ready"}, 64'(bus.write_ready), 64'd1);
    wr_log.delete();
    w0 = we_count;
    d0 = done_count;
    bus.matrix_id     = id;
    bus.actual_rows   = r;
    bus.actual_cols   = c;
    bus.matrix_name   = name;
    bus.write_request = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 400; i++) begin
      if (bus.write_done) begin
        done_at  = cyc;
        err_seen = bus.write_err;
        break;
      end
      dv = bus.writer_ready ? dv_pat(mode, k) : (mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      bus.data_valid = dv;
      bus.data_in    = (sent < n) ? dq[sent] : DW'($urandom);
      hs = bus.writer_ready && dv;
      if (bus.writer_ready) k++;
      step();
      bus.write_request = 1'b0;
      if (hs) sent++;
    end
    bus.write_request = 1'b0;
    bus.data_valid    = 1'b0;
    check({nm, " latency"}, 64'(done_at < 0 ? -1 : done_at - t0), 64'(exp_lat));
    check({nm, " write_err"}, 64'(err_seen), 64'(exp_err));
    check({nm, " write count"}, 64'(we_count - w0), 64'(exp_err ? 0 : 3 + n));
    base = AW'(id) * AW'(BS);
    if (!exp_err) begin
      exp_q.push_back('{base, DW'({r, c, 16'h0000})});
      exp_q.push_back('{base + AW'(1), DW'({name[0], name[1], name[2], name[3]})});
      exp_q.push_back('{base + AW'(2), DW'({name[4], name[5], name[6], name[7]})});
      for (int j = 0; j < n; j++) exp_q.push_back('{base + AW'(3 + j), dq[j]});
    end
    if (wr_log.size() != exp_q.size()) bad++;
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
      if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) bad++;
    check({nm, " write log"}, 64'(bad), 64'd0);
    step();
    check({nm, " done pulse width"}, 64'(bus.write_done), 64'd0);
    check({nm, " done count"}, 64'(done_count - d0), 64'd1);
    check({nm, " ready after"}, 64'(bus.write_ready), 64'd1);
  endtask

  vec_t vt[7];

  initial begin
    logic [0:7][7:0] src_name;
    int              sent, w0, d0, rr, cc, md;
    bit              hs;

    vt[0] = '{"v_2x3_toggle", 3'd1, 8'd2,   8'd3,   1, 0, 1'b0, 15};
    vt[1] = '{"v_1x1_idle3",  3'd3, 8'd1,   8'd1,   2, 7, 1'b0, 8};
    vt[2] = '{"v_rows0",      3'd2, 8'd0,   8'd5,   0, 0, 1'b1, 1};
    vt[3] = '{"v_255x255",    3'd4, 8'd255, 8'd255, 0, 0, 1'b1, 1};
    vt[4] = '{"v_cols0",      3'd5, 8'd5,   8'd0,   1, 0, 1'b1, 1};
    vt[5] = '{"v_1x61_max",   3'd6, 8'd1,   8'd61,  0, 0, 1'b0, 65};
    vt[6] = '{"v_2x31_over",  3'd7, 8'd2,   8'd31,  0, 0, 1'b1, 1};

    src_name = {"SRC", 40'h0};
    bus.write_request = 1'b0;
    bus.matrix_id     = '0;
    bus.actual_rows   = '0;
    bus.actual_cols   = '0;
    bus.matrix_name   = '0;
    bus.data_in       = '0;
    bus.data_valid    = 1'b0;

    rst = 1'b1;
    step();
    step();
    check("reset write_ready", 64'(bus.write_ready), 64'd1);
    check("reset writer_ready", 64'(bus.writer_ready), 64'd0);
    check("reset mem_we", 64'(bus.mem_we), 64'd0);
    check("reset write_done", 64'(bus.write_done), 64'd0);
    check("reset write_err", 64'(bus.write_err), 64'd0);
    rst = 1'b0;
    step();

    // id 0, 2x2 "SRC", no gaps, data_valid held high through the metadata cycles
    run_req("src_2x2", 3'd0, 8'd2, 8'd2, src_name, 0, 3, 8, 1'b0);
    check("src mem0", 64'(mem[0]), 64'h02020000);
    check("src mem1", 64'(mem[1]), 64'h53524300);
    check("src mem2", 64'(mem[2]), 64'h0);
    for (int i = 0; i < 4; i++) check($sformatf("src mem%0d", 3 + i), 64'(mem[3 + i]), 64'(3 * (i + 1)));

    foreach (vt[i])
      run_req(vt[i].nm, vt[i].id, vt[i].r, vt[i].c, {$urandom, $urandom}, vt[i].mode, vt[i].mult,
              vt[i].lat, vt[i].err);
    check("slot3 element", 64'(mem[3 * BS + 3]), 64'd7);

    // Reset after the second beat of a 2x2: no further writes and no completion.
    for (int i = 0; i < 50 && !bus.write_ready; i++) step();
    bus.matrix_id     = 3'd2;
    bus.actual_rows   = 8'd2;
    bus.actual_cols   = 8'd2;
    bus.matrix_name   = src_name;
    bus.write_request = 1'b1;
    step();
    bus.write_request = 1'b0;
    sent = 0;
    for (int i = 0; i < 20 && sent < 2; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = DW'(100 + sent);
      hs = bus.writer_ready;
      step();
      if (hs) sent++;
    end
    check("rst beats before reset", 64'(sent), 64'd2);
    w0 = we_count;
    d0 = done_count;
    rst = 1'b1;
    bus.data_valid = 1'b1;
    step();
    rst = 1'b0;
    check("rst write_ready", 64'(bus.write_ready), 64'd1);
    check("rst writer_ready", 64'(bus.writer_ready), 64'd0);
    for (int i = 0; i < 8; i++) step();
    check("rst no writes", 64'(we_count - w0), 64'd0);
    check("rst no done", 64'(done_count - d0), 64'd0);
    bus.data_valid = 1'b0;
    run_req("after_rst_1x1", 3'd2, 8'd1, 8'd1, src_name, 0, 0, 5, 1'b0);

    for (int t = 0; t < 24; t++) begin
      rr = (t % 8 == 7) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      cc = int'($urandom_range(0, 9));
      md = int'($urandom_range(0, 2));
      run_req($sformatf("rand%0d", t), 3'($urandom_range(0, 7)), 8'(rr), 8'(cc), {$urandom, $urandom},
              md, 0, model_accept(rr, cc) ? model_latency(md, rr * cc) : 1, !model_accept(rr, cc));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
